// File: rtl/bp_be_dcache_trace_checker.sv
// Response-side dcache trace checker: zero-latency in-order compare of v_i/data_i beats against a combinational expected-trace ROM; no backpressure (every beat is consumed or flagged).
// Optional stall watchdog is built only when BP_DCACHE_TRACE_CHECKER_TIMEOUT_EN is defined.
module bp_be_dcache_trace_checker
  #(parameter int dword_width_p    = 64
  , parameter int rom_addr_width_p = 20
  , parameter int count_width_p    = 32
  , parameter int timeout_p        = 1000000
  )
  (input  logic                          clk_i
  , input  logic                         reset_i
  , input  logic                         en_i
  , input  logic                         v_i
  , input  logic [dword_width_p-1:0]     data_i
  , output logic [rom_addr_width_p-1:0]  rom_addr_o
  , input  logic [4+dword_width_p-1:0]   rom_data_i
  , output logic [count_width_p-1:0]     resp_count_o
  , output logic [count_width_p-1:0]     mismatch_count_o
  , output logic [rom_addr_width_p-1:0]  first_fail_idx_o
  , output logic                         done_o
  , output logic                         error_o
  );

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0]               op;
    logic [dword_width_p-1:0] exp_dat;
  } rom_entry_t;

  localparam logic [3:0] OP_CHECK = 4'h0;
  localparam logic [3:0] OP_SKIP  = 4'h1;

  if (timeout_p < 2) begin : g_bad_timeout
    $error("timeout_p must be at least 2");
  end

  state_e                      state_q, state_d;
  logic [rom_addr_width_p-1:0] rom_addr_q, rom_addr_d;
  logic [count_width_p-1:0]    resp_count_q, resp_count_d;
  logic [count_width_p-1:0]    mismatch_count_q, mismatch_count_d;
  logic [rom_addr_width_p-1:0] first_fail_idx_q, first_fail_idx_d;
  logic                        fail_cap_q, fail_cap_d;

  rom_entry_t                  rom_entry;
  logic                        op_check;
  logic                        op_end;
  logic                        data_mismatch;
  logic                        rom_addr_last;
  logic [count_width_p-1:0]    resp_count_inc;
  logic [count_width_p-1:0]    mismatch_count_inc;
  logic                        fail_note;
  logic [rom_addr_width_p-1:0] fail_idx_dat;

  assign rom_entry     = rom_entry_t'(rom_data_i);
  assign op_check      = (rom_entry.op == OP_CHECK);
  // Every op other than CHECK/SKIP terminates the trace.
  assign op_end        = (rom_entry.op != OP_CHECK) && (rom_entry.op != OP_SKIP);
  assign data_mismatch = (rom_entry.exp_dat != data_i);
  assign rom_addr_last = &rom_addr_q;

  assign resp_count_inc     = (&resp_count_q)     ? resp_count_q     : resp_count_q + 1'b1;
  assign mismatch_count_inc = (&mismatch_count_q) ? mismatch_count_q : mismatch_count_q + 1'b1;

`ifdef BP_DCACHE_TRACE_CHECKER_TIMEOUT_EN
  localparam int StallW = $clog2(timeout_p);

  logic [StallW-1:0] stall_q, stall_d;
  logic              stall_hit;

  assign stall_hit = (stall_q == StallW'(timeout_p - 1));
`endif

  always_comb begin
    state_d          = state_q;
    rom_addr_d       = rom_addr_q;
    resp_count_d     = resp_count_q;
    mismatch_count_d = mismatch_count_q;
    first_fail_idx_d = first_fail_idx_q;
    fail_cap_d       = fail_cap_q;
    fail_note        = 1'b0;
    fail_idx_dat     = rom_addr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (v_i) begin
          state_d      = ST_FAIL;
          fail_note    = 1'b1;
          fail_idx_dat = '0;
        end else if (en_i) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (op_end) begin
          // A beat landing on the terminator is an overflow response.
          if (v_i) begin
            state_d   = ST_FAIL;
            fail_note = 1'b1;
          end else if (mismatch_count_q != '0) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_PASS;
          end
        end else if (v_i) begin
          resp_count_d = resp_count_inc;
          if (op_check && data_mismatch) begin
            mismatch_count_d = mismatch_count_inc;
            fail_note        = 1'b1;
          end
          if (rom_addr_last) begin
            state_d   = ST_FAIL;
            fail_note = 1'b1;
          end else begin
            rom_addr_d = rom_addr_q + 1'b1;
          end
        end
`ifdef BP_DCACHE_TRACE_CHECKER_TIMEOUT_EN
        else if (stall_hit) begin
          state_d   = ST_FAIL;
          fail_note = 1'b1;
        end
`endif
      end

      default: begin
      end
    endcase

    // First failure index is latched once and never overwritten.
    if (fail_note && !fail_cap_q) begin
      first_fail_idx_d = fail_idx_dat;
      fail_cap_d       = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q          <= ST_IDLE;
      rom_addr_q       <= '0;
      resp_count_q     <= '0;
      mismatch_count_q <= '0;
      first_fail_idx_q <= '0;
      fail_cap_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      rom_addr_q       <= rom_addr_d;
      resp_count_q     <= resp_count_d;
      mismatch_count_q <= mismatch_count_d;
      first_fail_idx_q <= first_fail_idx_d;
      fail_cap_q       <= fail_cap_d;
    end
  end

`ifdef BP_DCACHE_TRACE_CHECKER_TIMEOUT_EN
  // Idle-cycle count restarts on any beat and on any state change.
  always_comb begin
    stall_d = '0;
    if ((state_q == ST_RUN) && (state_d == ST_RUN) && !v_i) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!reset_i && (state_q == ST_RUN) && !v_i && !op_end && stall_hit) begin
      $error("stalled");
    end
  end
`endif
`endif

  assign rom_addr_o       = rom_addr_q;
  assign resp_count_o     = resp_count_q;
  assign mismatch_count_o = mismatch_count_q;
  assign first_fail_idx_o = first_fail_idx_q;
  assign done_o           = (state_q == ST_PASS) || (state_q == ST_FAIL);
  assign error_o          = (state_q == ST_FAIL)
                         || ((state_q == ST_RUN) && (mismatch_count_q != '0));

endmodule

// File: tb/tb_bp_be_dcache_trace_checker.sv
// Randomised and directed bench for bp_be_dcache_trace_checker with a trace-level reference model.
module tb_bp_be_dcache_trace_checker;
  localparam int DW  = 64;
  localparam int AW  = 4;
  localparam int CW  = 4;
  localparam int TO  = 16;
  localparam int ROM_N = 16;
  localparam int CMAX  = 15;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          en_i = 1'b0;
  logic          v_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [AW-1:0] rom_addr_o;
  logic [DW+3:0] rom_data_i;
  logic [CW-1:0] resp_count_o;
  logic [CW-1:0] mismatch_count_o;
  logic [AW-1:0] first_fail_idx_o;
  logic          done_o;
  logic          error_o;

  logic [DW+3:0] rom [ROM_N];

  int total = 0;
  int bad   = 0;

  // Trace-level model: position in trace, tallies, and outcome flags.
  int m_addr, m_resp, m_mism, m_ff;
  bit m_run, m_done, m_fail, m_cap;
`ifdef BP_DCACHE_TRACE_CHECKER_TIMEOUT_EN
  int m_stall;
`endif

  bp_be_dcache_trace_checker #(
    .dword_width_p   (DW),
    .rom_addr_width_p(AW),
    .count_width_p   (CW),
    .timeout_p       (TO)
  ) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .en_i            (en_i),
    .v_i             (v_i),
    .data_i          (data_i),
    .rom_addr_o      (rom_addr_o),
    .rom_data_i      (rom_data_i),
    .resp_count_o    (resp_count_o),
    .mismatch_count_o(mismatch_count_o),
    .first_fail_idx_o(first_fail_idx_o),
    .done_o          (done_o),
    .error_o         (error_o)
  );

  assign rom_data_i = rom[rom_addr_o];

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [17:0] obs();
    return {rom_addr_o, resp_count_o, mismatch_count_o, first_fail_idx_o, done_o, error_o};
  endfunction

  function automatic logic [17:0] expv();
    logic [3:0] a, r, mm, f;
    logic       e;
    a  = m_addr[3:0];
    r  = m_resp[3:0];
    mm = m_mism[3:0];
    f  = m_ff[3:0];
    e  = m_fail || (m_run && !m_done && (m_mism != 0));
    return {a, r, mm, f, m_done, e};
  endfunction

  task automatic model_reset();
    m_addr = 0; m_resp = 0; m_mism = 0; m_ff = 0;
    m_run = 0; m_done = 0; m_fail = 0; m_cap = 0;
`ifdef BP_DCACHE_TRACE_CHECKER_TIMEOUT_EN
    m_stall = 0;
`endif
  endtask

  task automatic note_fail(input int idx);
    if (!m_cap) begin
      m_cap = 1;
      m_ff  = idx;
    end
  endtask

  task automatic finish_fail(input int idx);
    note_fail(idx);
    m_done = 1;
    m_fail = 1;
  endtask

  // One clock of the trace rules, evaluated with the inputs present at the edge.
  task automatic model_step(input logic v, input logic [DW-1:0] d, input logic en);
    logic [3:0]    op;
    logic [DW-1:0] ex;
    if (m_done) return;
    if (!m_run) begin
      if (v) finish_fail(0);
      else if (en) m_run = 1;
      return;
    end
    op = rom[m_addr][DW+3:DW];
    ex = rom[m_addr][DW-1:0];
    if (op > 4'h1) begin
      if (v) finish_fail(m_addr);
      else begin
        m_done = 1;
        m_fail = (m_mism != 0);
      end
    end else if (v) begin
      m_resp = (m_resp < CMAX) ? m_resp + 1 : CMAX;
      if (op == 4'h0 && d !== ex) begin
        m_mism = (m_mism < CMAX) ? m_mism + 1 : CMAX;
        note_fail(m_addr);
      end
      if (m_addr == ROM_N - 1) finish_fail(m_addr);
      else m_addr = m_addr + 1;
`ifdef BP_DCACHE_TRACE_CHECKER_TIMEOUT_EN
      m_stall = 0;
    end else if (m_stall == TO - 1) begin
      finish_fail(m_addr);
    end else begin
      m_stall = m_stall + 1;
`endif
    end
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d);
    v_i    = v;
    data_i = d;
    @(posedge clk_i);
    model_step(v, d, en_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    en_i    = 1'b0;
    v_i     = 1'b0;
    data_i  = '0;
    @(posedge clk_i);
    #1;
    model_reset();
    reset_i = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < ROM_N; i++) rom[i] = {4'h2, 64'h0};
  endtask

  task automatic start_run();
    en_i = 1'b1;
    step(1'b0, '0);
    en_i = 1'b0;
  endtask

  task automatic test_reset();
    clear_rom();
    #1;
    total++;
    if (obs() !== 18'd0) begin
      bad++;
      $display("FAIL reset_async got=%h want=%h", obs(), 18'd0);
    end
    do_reset();
    step(1'b0, '0);
    total++;
    if (obs() !== 18'd0) begin
      bad++;
      $display("FAIL reset_idle got=%h want=%h", obs(), 18'd0);
    end
  endtask

  task automatic test_basic(input string tag);
    clear_rom();
    rom[0] = {4'h0, 64'h11};
    rom[1] = {4'h0, 64'h22};
    do_reset();
    start_run();
    step(1'b1, 64'h11);
    step(1'b1, 64'h22);
    total++;
    if (obs() !== expv() || done_o !== 1'b0) begin
      bad++;
      $display("FAIL %s_beats got=%h want=%h", tag, obs(), expv());
    end
    step(1'b0, '0);
    total++;
    if ({resp_count_o, mismatch_count_o, done_o, error_o} !== {4'd2, 4'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL %s_pass got=%h want=%h", tag,
               {resp_count_o, mismatch_count_o, done_o, error_o}, {4'd2, 4'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_skip_mismatch();
    clear_rom();
    rom[0] = {4'h0, 64'hAA};
    rom[1] = {4'h1, 64'h0};
    rom[2] = {4'h0, 64'hBB};
    do_reset();
    start_run();
    step(1'b1, 64'hAA);
    step(1'b1, 64'hDEAD);
    total++;
    if (error_o !== 1'b0 || mismatch_count_o !== 4'd0) begin
      bad++;
      $display("FAIL skip_ok got=%b/%0d want=0/0", error_o, mismatch_count_o);
    end
    step(1'b1, 64'hBC);
    total++;
    if ({mismatch_count_o, first_fail_idx_o, error_o, done_o} !== {4'd1, 4'd2, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL mismatch_run got=%h want=%h",
               {mismatch_count_o, first_fail_idx_o, error_o, done_o}, {4'd1, 4'd2, 1'b1, 1'b0});
    end
    step(1'b0, '0);
    total++;
    if (obs() !== expv() || {done_o, error_o} !== 2'b11) begin
      bad++;
      $display("FAIL mismatch_end got=%h want=%h", obs(), expv());
    end
  endtask

  task automatic test_overflow();
    clear_rom();
    rom[0] = {4'h0, 64'h1};
    do_reset();
    start_run();
    step(1'b1, 64'h1);
    step(1'b1, 64'h1);
    step(1'b1, 64'h1);
    total++;
    if ({resp_count_o, first_fail_idx_o, rom_addr_o, done_o, error_o} !== {4'd1, 4'd1, 4'd1, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL overflow got=%h want=%h",
               {resp_count_o, first_fail_idx_o, rom_addr_o, done_o, error_o}, {4'd1, 4'd1, 4'd1, 1'b1, 1'b1});
    end
  endtask

  task automatic test_idle_beat();
    clear_rom();
    rom[0] = {4'h0, 64'h7};
    do_reset();
    step(1'b0, '0);
    step(1'b1, 64'h7);
    step(1'b0, '0);
    total++;
    if ({done_o, error_o, first_fail_idx_o, resp_count_o} !== {1'b1, 1'b1, 4'd0, 4'd0}) begin
      bad++;
      $display("FAIL idle_beat got=%h want=%h",
               {done_o, error_o, first_fail_idx_o, resp_count_o}, {1'b1, 1'b1, 4'd0, 4'd0});
    end
  endtask

  task automatic test_reset_midrun();
    clear_rom();
    for (int i = 0; i < 8; i++) rom[i] = {4'h1, 64'h0};
    do_reset();
    start_run();
    for (int i = 0; i < 5; i++) step(1'b1, 64'(i));
    total++;
    if (obs() !== expv() || resp_count_o !== 4'd5) begin
      bad++;
      $display("FAIL midrun_pre got=%h want=%h", obs(), expv());
    end
    #2;
    reset_i = 1'b1;
    #1;
    total++;
    if (obs() !== 18'd0) begin
      bad++;
      $display("FAIL midrun_async got=%h want=%h", obs(), 18'd0);
    end
    test_basic("rerun");
  endtask

  task automatic test_wrap();
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < ROM_N; i++) rom[i] = {4'h0, 64'(i + 100)};
      do_reset();
      start_run();
      for (int i = 0; i <= ROM_N; i++) step(1'b1, (pass == 0) ? 64'(i + 100) : 64'(i + 7));
      total++;
      if (obs() !== expv()) begin
        bad++;
        $display("FAIL wrap_model%0d got=%h want=%h", pass, obs(), expv());
      end
      total++;
      if ({rom_addr_o, resp_count_o, mismatch_count_o, first_fail_idx_o, done_o, error_o} !==
          {4'd15, 4'd15, (pass == 0) ? 4'd0 : 4'd15, (pass == 0) ? 4'd15 : 4'd0, 1'b1, 1'b1}) begin
        bad++;
        $display("FAIL wrap_sat%0d got=%h", pass, obs());
      end
    end
  endtask

  task automatic test_timeout();
    clear_rom();
    rom[0] = {4'h0, 64'h5};
    do_reset();
    start_run();
`ifdef BP_DCACHE_TRACE_CHECKER_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) step(1'b0, '0);
    total++;
    if (done_o !== 1'b0) begin
      bad++;
      $display("FAIL timeout_early got=%b want=0", done_o);
    end
    step(1'b0, '0);
    total++;
    if ({done_o, error_o, first_fail_idx_o} !== {1'b1, 1'b1, 4'd0}) begin
      bad++;
      $display("FAIL timeout_fire got=%h want=%h", {done_o, error_o, first_fail_idx_o}, {1'b1, 1'b1, 4'd0});
    end
`else
    for (int i = 0; i < 100; i++) step(1'b0, '0);
    total++;
    if ({done_o, error_o, resp_count_o} !== {1'b0, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL no_timeout got=%h want=%h", {done_o, error_o, resp_count_o}, {1'b0, 1'b0, 4'd0});
    end
    step(1'b1, 64'h5);
    step(1'b0, '0);
    total++;
    if ({resp_count_o, done_o, error_o} !== {4'd1, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL late_beat got=%h want=%h", {resp_count_o, done_o, error_o}, {4'd1, 1'b1, 1'b0});
    end
`endif
  endtask

  task automatic test_random();
    int            len;
    logic          v;
    logic [DW-1:0] d;
    for (int it = 0; it < 25; it++) begin
      len = $urandom_range(1, ROM_N);
      for (int i = 0; i < ROM_N; i++) begin
        d = {$urandom(), $urandom()};
        if (i < len) rom[i] = {4'($urandom_range(0, 1)), d};
        else rom[i] = {4'($urandom_range(2, 15)), d};
      end
      do_reset();
      start_run();
      for (int c = 0; c < 40; c++) begin
        v = ($urandom_range(0, 9) < 7);
        d = ($urandom_range(0, 3) == 0) ? {$urandom(), $urandom()} : rom[m_addr][DW-1:0];
        step(v, d);
        total++;
        if (obs() !== expv()) begin
          bad++;
          $display("FAIL random it=%0d cyc=%0d got=%h want=%h", it, c, obs(), expv());
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic("basic");
    test_skip_mismatch();
    test_overflow();
    test_idle_beat();
    test_reset_midrun();
    test_wrap();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
